// File: rtl/one_by_two_demux.sv
`default_nettype none
// ============================================================================
// Module      : one_by_two_demux
// Description : Steers one producer stream to one of two sinks, chosen per
//               word by a select bit. Each sink has its own small FIFO so a
//               stalled sink never blocks traffic queued for the other one.
//               Also keeps a wrapping count of words accepted per output.
// Revision    : 1.0 - initial release
// ============================================================================
module one_by_two_demux #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  control_signal_demux_1_by_2,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out1_data,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [DATA_WIDTH-1:0] out2_data,
    output logic                  out2_valid,
    input  logic                  out2_ready,
    output logic [CNT_WIDTH-1:0]  count1,
    output logic [CNT_WIDTH-1:0]  count2
);

    // Pointer width, and occupancy width (one extra bit so "full" is encodable)
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;
    localparam logic [OW-1:0] c_full_level = OW'(DEPTH);

    // Per-FIFO status and head data, index 0 -> out1, index 1 -> out2
    logic [1:0]            w_full;
    logic [1:0]            w_valid;
    logic [1:0]            w_ready;
    logic [DATA_WIDTH-1:0] w_head [2];
    logic [CNT_WIDTH-1:0]  w_cnt  [2];

    assign w_ready = {out2_ready, out1_ready};

    // Acceptance looks only at the FIFO the current word is bound for; a full
    // FIFO stays not-ready even if its sink pops this cycle (no bypass path).
    assign in_ready = control_signal_demux_1_by_2 ? ~w_full[1] : ~w_full[0];

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        localparam logic c_sel = 1'(g);

        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [AW-1:0]         wr_ptr_q;
        logic [AW-1:0]         wr_ptr_d;
        logic [AW-1:0]         rd_ptr_q;
        logic [AW-1:0]         rd_ptr_d;
        logic [OW-1:0]         occ_q;
        logic [OW-1:0]         occ_d;
        logic [CNT_WIDTH-1:0]  cnt_q;
        logic [CNT_WIDTH-1:0]  cnt_d;
        logic                  w_push;
        logic                  w_pop;

        // Select is sampled only in the transfer cycle
        assign w_push = in_valid & in_ready
                      & (control_signal_demux_1_by_2 == c_sel);
        // Pop on an empty FIFO is ignored
        assign w_pop  = (occ_q != '0) & w_ready[g];

        assign w_full[g]  = (occ_q == c_full_level);
        assign w_valid[g] = (occ_q != '0);
        assign w_head[g]  = mem_q[rd_ptr_q];
        assign w_cnt[g]   = cnt_q;

        // Next-state for pointers, occupancy and accepted-word counter;
        // pointers wrap naturally because DEPTH is a power of two
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            occ_d    = occ_q;
            cnt_d    = cnt_q;
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                cnt_d    = cnt_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end

        // Control state registers, cleared asynchronously
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                occ_q    <= occ_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage; cleared on reset so the head reads 0 right away
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    mem_q[i] <= '0;
                end
            end else if (w_push) begin
                mem_q[wr_ptr_q] <= in_data;
            end
        end
    end

    assign out1_data  = w_head[0];
    assign out1_valid = w_valid[0];
    assign out2_data  = w_head[1];
    assign out2_valid = w_valid[1];
    assign count1     = w_cnt[0];
    assign count2     = w_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_one_by_two_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_one_by_two_demux
// Description : Directed, table-driven bench for one_by_two_demux plus
//               hand-written reset-flush and counter-wrap sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_one_by_two_demux;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       sel;
    logic       in_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out2_data;
    logic       out2_valid;
    logic       out2_ready;
    logic [7:0] count1;
    logic [7:0] count2;

    int checks = 0;
    int errors = 0;

    one_by_two_demux #(
        .DATA_WIDTH (8),
        .DEPTH      (2),
        .CNT_WIDTH  (8)
    ) u_dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .in_data                     (in_data),
        .in_valid                    (in_valid),
        .control_signal_demux_1_by_2 (sel),
        .in_ready                    (in_ready),
        .out1_data                   (out1_data),
        .out1_valid                  (out1_valid),
        .out1_ready                  (out1_ready),
        .out2_data                   (out2_data),
        .out2_valid                  (out2_valid),
        .out2_ready                  (out2_ready),
        .count1                      (count1),
        .count2                      (count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       s;
        logic [7:0] d;
        logic       r1;
        logic       r2;
        logic       ir;
        logic       o1v;
        logic [7:0] o1d;
        logic       o2v;
        logic [7:0] o2d;
        logic [7:0] c1;
        logic [7:0] c2;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic v, input logic s, input logic [7:0] d,
                                input logic r1, input logic r2, input logic ir,
                                input logic o1v, input logic [7:0] o1d,
                                input logic o2v, input logic [7:0] o2d,
                                input logic [7:0] c1, input logic [7:0] c2);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.r1 = r1; t.r2 = r2; t.ir = ir;
        t.o1v = o1v; t.o1d = o1d; t.o2v = o2v; t.o2d = o2d; t.c1 = c1; t.c2 = c2;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d,
                         input logic r1, input logic r2);
        in_valid   = v;
        sel        = s;
        in_data    = d;
        out1_ready = r1;
        out2_ready = r2;
    endtask

    initial begin
        // Row = inputs applied this cycle, expected = outputs seen before the edge
        //            v  s  d      r1 r2  ir o1v o1d    o2v o2d    c1 c2
        vecs[0]  = mk(1, 0, 8'h11, 1, 1,  1, 0, 8'h00,  0, 8'h00,  0, 0);
        vecs[1]  = mk(1, 1, 8'h22, 1, 1,  1, 1, 8'h11,  0, 8'h00,  1, 0);
        vecs[2]  = mk(1, 0, 8'h33, 1, 1,  1, 0, 8'h00,  1, 8'h22,  1, 1);
        vecs[3]  = mk(0, 0, 8'h00, 1, 1,  1, 1, 8'h33,  0, 8'h00,  2, 1);
        vecs[4]  = mk(1, 0, 8'hA0, 0, 1,  1, 0, 8'h00,  0, 8'h00,  2, 1);
        vecs[5]  = mk(1, 0, 8'hA1, 0, 1,  1, 1, 8'hA0,  0, 8'h00,  3, 1);
        vecs[6]  = mk(1, 0, 8'hA2, 0, 1,  0, 1, 8'hA0,  0, 8'h00,  4, 1);
        vecs[7]  = mk(1, 1, 8'hB0, 0, 1,  1, 1, 8'hA0,  0, 8'h00,  4, 1);
        vecs[8]  = mk(1, 0, 8'hA2, 1, 1,  0, 1, 8'hA0,  1, 8'hB0,  4, 2);
        vecs[9]  = mk(1, 0, 8'hA2, 1, 1,  1, 1, 8'hA1,  0, 8'h00,  4, 2);
        vecs[10] = mk(0, 0, 8'h00, 1, 1,  1, 1, 8'hA2,  0, 8'h00,  5, 2);
        vecs[11] = mk(1, 0, 8'h55, 0, 0,  1, 0, 8'h00,  0, 8'h00,  5, 2);
        vecs[12] = mk(1, 0, 8'h66, 1, 0,  1, 1, 8'h55,  0, 8'h00,  6, 2);
        vecs[13] = mk(0, 0, 8'h00, 0, 0,  1, 1, 8'h66,  0, 8'h00,  7, 2);
        vecs[14] = mk(0, 0, 8'h00, 1, 0,  1, 1, 8'h66,  0, 8'h00,  7, 2);
        vecs[15] = mk(0, 0, 8'h00, 0, 0,  1, 0, 8'h00,  0, 8'h00,  7, 2);
        vecs[16] = mk(1, 1, 8'hC0, 0, 0,  1, 0, 8'h00,  0, 8'h00,  7, 2);
        vecs[17] = mk(1, 1, 8'hC1, 0, 0,  1, 0, 8'h00,  1, 8'hC0,  7, 3);
        vecs[18] = mk(1, 1, 8'hC2, 0, 1,  0, 0, 8'h00,  1, 8'hC0,  7, 4);
        vecs[19] = mk(1, 1, 8'hC2, 0, 0,  1, 0, 8'h00,  1, 8'hC1,  7, 4);
        vecs[20] = mk(1, 0, 8'hD0, 0, 0,  1, 0, 8'h00,  1, 8'hC1,  7, 5);
        vecs[21] = mk(0, 1, 8'h00, 1, 1,  0, 1, 8'hD0,  1, 8'hC1,  8, 5);
        vecs[22] = mk(0, 1, 8'h00, 1, 1,  1, 0, 8'h00,  1, 8'hC2,  8, 5);
        vecs[23] = mk(0, 0, 8'h00, 1, 1,  1, 0, 8'h00,  0, 8'h00,  8, 5);

        rst_n = 1'b1;
        drive(0, 0, 8'h00, 0, 0);

        // Asynchronous reset asserted mid-cycle, checked before any edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out1_valid", 32'(out1_valid), 0);
        chk("rst_out2_valid", 32'(out2_valid), 0);
        chk("rst_out1_data",  32'(out1_data),  0);
        chk("rst_out2_data",  32'(out2_data),  0);
        chk("rst_count1",     32'(count1),     0);
        chk("rst_count2",     32'(count2),     0);
        chk("rst_in_ready",   32'(in_ready),   1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            chk("idle_out1_valid", 32'(out1_valid), 0);
            chk("idle_out2_valid", 32'(out2_valid), 0);
        end

        // Table-driven main sequence
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r1, vecs[i].r2);
            #1;
            chk($sformatf("v%0d_in_ready", i),   32'(in_ready),   32'(vecs[i].ir));
            chk($sformatf("v%0d_out1_valid", i), 32'(out1_valid), 32'(vecs[i].o1v));
            chk($sformatf("v%0d_out2_valid", i), 32'(out2_valid), 32'(vecs[i].o2v));
            if (vecs[i].o1v)
                chk($sformatf("v%0d_out1_data", i), 32'(out1_data), 32'(vecs[i].o1d));
            if (vecs[i].o2v)
                chk($sformatf("v%0d_out2_data", i), 32'(out2_data), 32'(vecs[i].o2d));
            chk($sformatf("v%0d_count1", i), 32'(count1), 32'(vecs[i].c1));
            chk($sformatf("v%0d_count2", i), 32'(count2), 32'(vecs[i].c2));
        end

        // Reset flush: queue two words in FIFO 1, then reset mid-cycle
        @(negedge clk); drive(1, 0, 8'hE0, 0, 0);
        @(negedge clk); drive(1, 0, 8'hE1, 0, 0);
        @(negedge clk); drive(0, 0, 8'h00, 0, 0);
        #1;
        chk("flush_pre_valid", 32'(out1_valid), 1);
        chk("flush_pre_data",  32'(out1_data),  32'h0E0);
        chk("flush_pre_count", 32'(count1),     10);
        chk("flush_pre_full",  32'(in_ready),   0);
        #2 rst_n = 1'b0;
        #1;
        chk("flush_out1_valid", 32'(out1_valid), 0);
        chk("flush_out1_data",  32'(out1_data),  0);
        chk("flush_count1",     32'(count1),     0);
        chk("flush_count2",     32'(count2),     0);
        chk("flush_in_ready",   32'(in_ready),   1);
        @(negedge clk);
        rst_n = 1'b1;
        out1_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("flush_post_valid", 32'(out1_valid), 0);
        end

        // Counter wrap: 256 words to out2 with continuous draining
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            drive(1, 1, 8'(i), 1, 1);
            #1;
            chk("wrap_in_ready", 32'(in_ready), 1);
            chk("wrap_count2",   32'(count2),   32'(i));
            if (i > 0) begin
                chk("wrap_out2_valid", 32'(out2_valid), 1);
                chk("wrap_out2_data",  32'(out2_data),  32'(i - 1));
            end
        end
        @(negedge clk);
        drive(0, 1, 8'h00, 1, 1);
        #1;
        chk("wrap_final_count2", 32'(count2),     0);
        chk("wrap_final_count1", 32'(count1),     0);
        chk("wrap_last_valid",   32'(out2_valid), 1);
        chk("wrap_last_data",    32'(out2_data),  32'h0FF);
        @(negedge clk); #1;
        chk("wrap_drained", 32'(out2_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/one_by_two_demux.md
Name: one_by_two_demux

Overview:
- Routing counterpart to the datapath's 2:1 mux: steers one 8-bit source stream to one of two sinks, chosen per word by a select bit.
- Each output has its own small FIFO, so one stalled sink does not block words bound for the other once they are queued.
- Sits between a shared producer (e.g. ALU/result bus) and two consumers (e.g. register file write port and memory write path).

Parameters:
- DATA_WIDTH, 8, width of data words.
- DEPTH, 2, entries per output FIFO; power of two, at least 2.
- CNT_WIDTH, 8, width of per-output word counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  word from producer.
- in_valid  input  1  producer offers in_data.
- control_signal_demux_1_by_2  input  1  0 routes to out1, 1 routes to out2.
- in_ready  output  1  block accepts the word this cycle.
- out1_data  output  DATA_WIDTH  head of FIFO 1.
- out1_valid  output  1  FIFO 1 not empty.
- out1_ready  input  1  sink 1 consumes the head.
- out2_data  output  DATA_WIDTH  head of FIFO 2.
- out2_valid  output  1  FIFO 2 not empty.
- out2_ready  input  1  sink 2 consumes the head.
- count1  output  CNT_WIDTH  words accepted for out1 since reset.
- count2  output  CNT_WIDTH  words accepted for out2 since reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All FIFO pointers, occupancy counts, storage, count1 and count2 clear to 0.
  - out1_valid and out2_valid go to 0 and out1_data and out2_data go to 0 immediately.
  - Reset mid-operation discards all queued words.
  - Operation resumes on the first rising edge after rst_n rises.
- Handshake and acceptance:
  - Input transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - Output transfer occurs where outN_valid=1 and outN_ready=1.
  - in_ready is combinational: in_ready = not full(FIFO selected by control_signal_demux_1_by_2). It does not depend on in_valid.
  - The select bit is sampled only in the transfer cycle. It may change every cycle.
  - A full FIFO deasserts in_ready even if its sink pops in the same cycle; there is no full-bypass path.
  - A full FIFO never blocks a word bound for the other FIFO.
- FIFO operation:
  - On transfer, in_data is written at the selected FIFO's write pointer. The write pointer increments modulo DEPTH and occupancy increments.
  - On output transfer, the read pointer increments modulo DEPTH and occupancy decrements.
  - Push and pop on the same FIFO in the same cycle (not full): occupancy is unchanged and both pointers advance.
  - Pop on an empty FIFO is ignored; outN_ready is don't-care when outN_valid=0.
- Latency: a word accepted at edge k appears on outN_data with outN_valid=1 after edge k (1 cycle). There is no combinational path from in_data to outN_data.
- Output data: outN_data is the entry at the read pointer. It holds stable while outN_valid=1 and outN_ready=0.
- Ordering: per-output FIFO order is preserved. There is no ordering guarantee between out1 and out2.
- Counters:
  - countN increments by 1 on each input transfer routed to N.
  - It wraps from 2^CNT_WIDTH-1 to 0 with no saturation and no flag.
- Occupancy:
  - Held in a register of log2(DEPTH)+1 bits.
  - full means occupancy == DEPTH; empty means occupancy == 0.

Test Plan:
- Reset then idle: rst_n=0 asserted asynchronously mid-cycle -> out1_valid=out2_valid=0, count1=count2=0, in_ready=1 immediately. Release rst_n with in_valid=0 -> outputs stay idle.
- Alternate routing: send 0x11 (sel=0), 0x22 (sel=1), 0x33 (sel=0) with both sinks ready=1 -> out1 delivers 0x11, 0x33 and out2 delivers 0x22, each one cycle after acceptance. Final counts: count1=2, count2=1.
- Backpressure and full:
  - With out1_ready=0, send 0xA0, 0xA1, 0xA2 all with sel=0 -> first two accepted, in_ready=0 on the third while sel=0.
  - Switch sel=1 with 0xB0 -> accepted, out2 delivers 0xB0.
  - Raise out1_ready -> 0xA0 then 0xA1 delivered, after which 0xA2 is accepted.
- Simultaneous push and pop: FIFO 1 holds 1 entry (0x55). Push 0x66 (sel=0) while out1_ready=1 -> 0x55 popped, occupancy stays 1, next head is 0x66.
- Full with pop: FIFO 2 full (DEPTH=2), out2_ready=1, in_valid=1, sel=1 -> in_ready=0 that cycle, one word popped. Next cycle in_ready=1.
- Counter wrap and reset flush:
  - Push 256 words with sel=1, draining continuously -> count2 returns to 0.
  - Assert rst_n=0 with 2 words queued in FIFO 1 -> out1_valid drops at once, and the words never appear after release.
